// File: rtl/ieee754_div.sv
// Multi-cycle IEEE-754 single-precision divider: radix-2 restoring, one quotient bit per cycle.
// Denormals flush to zero, truncation rounding, overflow clamps to max finite.
module ieee754_div #(
    parameter int QBITS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] dest,
    output logic        div_by_zero,
    output logic        invalid
);
    localparam int CW = $clog2(QBITS);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic               inv_q, inv_d;
    logic [31:0]        dest_q, dest_d;
    logic               sign_q, sign_d;
    logic [7:0]         ea_q, ea_d;
    logic [7:0]         eb_q, eb_d;
    logic               za_q, za_d;
    logic               zb_q, zb_d;
    logic [QBITS-1:0]   rem_q, rem_d;
    logic [QBITS-2:0]   div_q, div_d;
    logic [QBITS-1:0]   quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               ge;
    logic [QBITS-1:0]   rem_nxt;
    logic signed [9:0]  exp_w;
    logic [22:0]        frac_w;

    always_comb begin
        ge      = rem_q >= {1'b0, div_q};
        rem_nxt = ge ? (rem_q - {1'b0, div_q}) : rem_q;
        exp_w   = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                + (quo_q[QBITS-1] ? 10'sd127 : 10'sd126);
        frac_w  = quo_q[QBITS-1] ? quo_q[QBITS-2:1] : quo_q[QBITS-3:0];
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        inv_d   = inv_q;
        dest_d  = dest_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        za_d    = za_q;
        zb_d    = zb_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // busy stays high through the done cycle so a start there is ignored
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    busy_d  = 1'b1;
                    dz_d    = 1'b0;
                    inv_d   = 1'b0;
                    sign_d  = src_a[31] ^ src_b[31];
                    ea_d    = src_a[30:23];
                    eb_d    = src_b[30:23];
                    za_d    = (src_a[30:23] == 8'h00);
                    zb_d    = (src_b[30:23] == 8'h00);
                    rem_d   = {1'b0, 1'b1, src_a[22:0]};
                    div_d   = {1'b1, src_b[22:0]};
                    quo_d   = '0;
                    cnt_d   = CW'(QBITS - 1);
                    state_d = (za_d || zb_d) ? NORM : DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = rem_nxt << 1;
                quo_d = {quo_q[QBITS-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = NORM;
            end
            NORM: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (za_q && zb_q) begin
                    dest_d = 32'h7FBF_FFFF;
                    inv_d  = 1'b1;
                end else if (zb_q) begin
                    dest_d = {sign_q, 8'hFF, 23'h0};
                    dz_d   = 1'b1;
                end else if (za_q) begin
                    dest_d = {sign_q, 31'h0};
                end else if (exp_w >= 10'sd255) begin
                    dest_d = {sign_q, 8'hFE, 23'h7F_FFFF};
                end else if (exp_w <= 10'sd0) begin
                    dest_d = {sign_q, 31'h0};
                end else begin
                    dest_d = {sign_q, exp_w[7:0], frac_w};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            inv_q   <= 1'b0;
            dest_q  <= '0;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            za_q    <= 1'b0;
            zb_q    <= 1'b0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            inv_q   <= inv_d;
            dest_q  <= dest_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            za_q    <= za_d;
            zb_q    <= zb_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign dest        = dest_q;
    assign div_by_zero = dz_q;
    assign invalid     = inv_q;
endmodule

// File: tb/tb_ieee754_div.sv
// Bench for ieee754_div: directed corner cases, handshake/reset scenarios and random operands
// compared against an integer-arithmetic reference model.
module tb_ieee754_div;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] dest;
    logic        div_by_zero;
    logic        invalid;

    int n_tests = 0;
    int n_fail  = 0;

    ieee754_div #(.QBITS(25)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .dest(dest), .div_by_zero(div_by_zero), .invalid(invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // returns {invalid, div_by_zero, dest}
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic  s;
        int    ea, eb, e;
        longint ma, mb, q;
        logic [22:0] fr;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 && eb == 0) return {2'b10, 32'h7FBF_FFFF};
        if (eb == 0)            return {2'b01, s, 8'hFF, 23'h0};
        if (ea == 0)            return {2'b00, s, 31'h0};
        ma = longint'(a[22:0]) + (64'd1 << 23);
        mb = longint'(b[22:0]) + (64'd1 << 23);
        q  = (ma << 24) / mb;
        if (q >= (64'd1 << 24)) begin
            fr = 23'((q >> 1) & 64'h7F_FFFF);
            e  = ea - eb + 127;
        end else begin
            fr = 23'(q & 64'h7F_FFFF);
            e  = ea - eb + 126;
        end
        if (e >= 255) return {2'b00, s, 8'hFE, 23'h7F_FFFF};
        if (e <= 0)   return {2'b00, s, 31'h0};
        return {2'b00, s, 8'(e), fr};
    endfunction

    // Issue a divide once the unit is free, wait (bounded) for done.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] d, output logic dz, output logic inv,
                          output int lat, output logic bok);
        @(negedge clk);
        while (busy) @(negedge clk);
        src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_a = $urandom; src_b = $urandom;
        lat = 0; bok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) bok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b1) bok = 1'b0;
        d = dest; dz = div_by_zero; inv = invalid;
    endtask

    logic [31:0] d;
    logic        dz, inv, bok, seen;
    int          lat;
    logic [33:0] r;
    logic [31:0] ta, tb;

    logic [31:0] dir_a   [8] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                                 32'h00000000, 32'h80000000, 32'h7F000000, 32'h00800000};
    logic [31:0] dir_b   [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000,
                                 32'h80000000, 32'h3F800000, 32'h00800000, 32'h7F000000};
    logic [31:0] dir_exp [8] = '{32'h40400000, 32'h3EAAAAAA, 32'hBE800000, 32'h7F800000,
                                 32'h7FBFFFFF, 32'h80000000, 32'h7F7FFFFF, 32'h00000000};
    logic [1:0]  dir_fl  [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    int          dir_lat [8] = '{26, 26, 26, 1, 1, 1, 26, 26};

    initial begin
        rst_n = 1'b0; start = 1'b0; src_a = '0; src_b = '0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_dest", dest, 32'h0);
        chk("rst_flags", {30'h0, invalid, div_by_zero}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_div(dir_a[i], dir_b[i], d, dz, inv, lat, bok);
            chk($sformatf("dir%0d_dest", i), d, dir_exp[i]);
            chk($sformatf("dir%0d_flags", i), {30'h0, inv, dz}, {30'h0, dir_fl[i]});
            chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(dir_lat[i]));
            chk($sformatf("dir%0d_busy", i), {31'h0, bok}, 32'h1);
        end
        do_div(32'h00000001, 32'h3F800000, d, dz, inv, lat, bok);
        chk("denorm_dest", d, 32'h0);

        // starts while busy and in the done cycle are ignored
        @(negedge clk);
        while (busy) @(negedge clk);
        src_a = 32'h40C00000; src_b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 0;
        repeat (4) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        src_a = 32'h3F800000; src_b = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        lat++; start = 1'b0;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("ign_lat", 32'(lat), 32'd26);
        chk("ign_dest", dest, 32'h40400000);
        chk("ign_dz", {31'h0, div_by_zero}, 32'h0);
        @(negedge clk);
        src_a = 32'h3F800000; src_b = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_done_busy", {31'h0, busy}, 32'h0);
        chk("ign_done_done", {31'h0, done}, 32'h0);
        do_div(32'h3F800000, 32'h40400000, d, dz, inv, lat, bok);
        chk("b2b_dest", d, 32'h3EAAAAAA);
        chk("b2b_lat", 32'(lat), 32'd26);

        // reset in the middle of a divide
        @(negedge clk);
        src_a = 32'h40C00000; src_b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_done", {31'h0, done}, 32'h0);
        chk("mid_rst_dest", dest, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        chk("mid_rst_nodone", {31'h0, seen}, 32'h0);
        do_div(32'hC1200000, 32'h40A00000, d, dz, inv, lat, bok);
        chk("post_rst_dest", d, 32'hC0000000);

        // random operands against the reference model
        for (int i = 0; i < 60; i++) begin
            ta = $urandom; tb = $urandom;
            if ($urandom_range(0, 1) == 0) ta[30:23] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 1) == 0) tb[30:23] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 9) == 0) ta[30:23] = 8'h00;
            if ($urandom_range(0, 9) == 0) tb[30:23] = 8'h00;
            r = ref_div(ta, tb);
            do_div(ta, tb, d, dz, inv, lat, bok);
            chk($sformatf("rnd%0d_dest %h/%h", i, ta, tb), d, r[31:0]);
            chk($sformatf("rnd%0d_flags", i), {30'h0, inv, dz}, {30'h0, r[33:32]});
            chk($sformatf("rnd%0d_lat", i), 32'(lat),
                (ta[30:23] == 8'h0 || tb[30:23] == 8'h0) ? 32'd1 : 32'd26);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ieee754_div.md
Name: ieee754_div

Overview:
- Multi-cycle IEEE-754 single-precision divider (FDIV path). It is the inverse of the FPU multiply/MAC pipeline.
- Computes dest = src_a / src_b with a radix-2 restoring divider, producing one quotient bit per cycle.
- A start/busy/done handshake lets the FPU issue logic stall while the divide is in flight.
- Uses the same number-handling rules as the multiplier: denormals flush to zero, truncation rounding, and overflow clamps to max finite.

Parameters:
- QBITS, 25, number of quotient bits generated (1 integer bit + 24 fraction bits); fixes the iteration count.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a divide; accepted only when busy=0
- src_a  input  32  dividend, IEEE-754 single
- src_b  input  32  divisor, IEEE-754 single
- busy  output  1  high while a divide is in progress
- done  output  1  one-cycle pulse; dest is valid from this cycle onward
- dest  output  32  quotient, held until the next completion
- div_by_zero  output  1  valid with done: nonzero/zero
- invalid  output  1  valid with done: zero/zero

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, div_by_zero, invalid and dest all 0. Reset mid-divide aborts the operation, and no done pulse is produced.
- Field rules:
  - An exponent of 0 means the operand is zero (sign kept, fraction ignored).
  - An exponent of 0xFF is treated as an ordinary finite value; there is no inf/NaN input handling.
  - Result sign = sign_a ^ sign_b.
- States: IDLE, DIVIDE, NORM.
- IDLE:
  - On a clk edge with start=1, operands are captured and busy goes high.
  - If an operand is zero, take the special path (below). Otherwise go to DIVIDE with:
    - rem = {1'b0, 1, frac_a} (25 bits)
    - div = {1, frac_b}
    - quotient register cleared
    - bit counter = QBITS-1
- DIVIDE (one bit per edge, QBITS edges total):
  - If rem >= div: rem = (rem - div) << 1 and the quotient bit is 1.
  - Otherwise: rem = rem << 1 and the quotient bit is 0.
  - Bits fill from MSB q[24] down to q[0].
  - After the edge that writes q[0], go to NORM.
- NORM (one edge):
  - If q[24]=1: frac = q[23:1], e = ea - eb + 127.
  - Else: frac = q[22:0], e = ea - eb + 126.
  - e is computed as a 10-bit signed value.
  - e >= 255 gives overflow: dest = {sign, 8'hFE, 23'h7FFFFF}.
  - e <= 0 gives underflow: dest = {sign, 31'h0}.
  - Otherwise dest = {sign, e[7:0], frac}. Rounding is truncation only; the remainder is discarded.
  - Register dest, pulse done=1, drop busy, return to IDLE.
- Special path (result written on the edge after the accepting edge, done pulses, busy drops):
  - a=0, b≠0: dest = {sign, 31'h0}.
  - a≠0, b=0: dest = {sign, 8'hFF, 23'h0}, div_by_zero=1.
  - a=0, b=0: dest = 32'h7FBFFFFF (SH4 default qNaN), invalid=1.
- Latency (normal case):
  - start accepted at edge 0.
  - Quotient bits written at edges 1..25.
  - NORM at edge 26, so done is high in the cycle after edge 26 (26 cycles after acceptance).
- Latency (special case): done is high in the cycle after edge 1.
- Flags are valid together with done and hold until the next accepted start. A new accepted start clears the flags.
- Handshake:
  - start while busy=1 is ignored; no queuing, and the operands are not re-sampled.
  - start in the same cycle as done is ignored, because busy is still high.
  - start may be asserted again in the cycle after done.
  - done never asserts without a preceding accepted start.
- Inputs are only sampled on the accepting edge; changes to src_a/src_b during DIVIDE have no effect.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> dest=0x40400000, done exactly 26 cycles after the accepting edge, busy high throughout.
- 0x3F800000 / 0x40400000 (1/3) -> dest=0x3EAAAAAA (truncated, q[24]=0 path); 0xBF800000 / 0x40800000 -> dest=0xBE800000 (q[24]=1 path).
- 0x3F800000 / 0x00000000 -> dest=0x7F800000, div_by_zero=1, done after 1 cycle; 0x00000000 / 0x80000000 -> 0x7FBFFFFF, invalid=1; 0x80000000 / 0x3F800000 -> 0x80000000, flags 0.
- Overflow: 0x7F000000 / 0x00800000 -> 0x7F7FFFFF. Underflow: 0x00800000 / 0x7F000000 -> 0x00000000. Denormal dividend 0x00000001 / 0x3F800000 -> 0x00000000.
- Start pulses with other operands at cycles 5 and 26 of an in-flight 6.0/2.0 divide -> ignored, dest=0x40400000; a back-to-back start the cycle after done is accepted.
- rst_n low at cycle 10 of a divide -> busy, done, dest = 0 immediately, no done pulse follows. A divide after reset completes correctly.
